// File: rtl/perf_event_counters.sv
`default_nettype none
// ============================================================================
//  Module      : perf_event_counters
//  Description : Parametrised bank of per-cycle event counters plus a run-cycle
//                counter. Counting happens only in RUN; a halt freezes the
//                bank. A snapshot copy of all counters is read back through a
//                registered, indexed read port.
//  Revision    : 1.0 - initial release
// ============================================================================
module perf_event_counters #(
    parameter int NUM_EVENTS = 8,
    parameter int CNT_W      = 32,
    parameter int SAT        = 1,
    localparam int IDX_W     = $clog2(NUM_EVENTS + 1),
    localparam int NUM_CNT   = NUM_EVENTS + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,
    input  logic                  hlt,
    input  logic [NUM_EVENTS-1:0] events,
    input  logic                  clear,
    input  logic                  snap,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [CNT_W-1:0]      rd_data,
    output logic [NUM_CNT-1:0]    overflow,
    output logic [1:0]            state
);

    // Explicitly encoded so the state output can be driven straight from the
    // register without a translation table.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        FROZEN = 2'b10
    } state_t;

    state_t r_state;
    state_t w_stateNext;

    // Counter NUM_EVENTS (the top entry) is the run-cycle counter.
    logic [CNT_W-1:0]   r_liveCnt [NUM_CNT];
    logic [CNT_W-1:0]   r_snapCnt [NUM_CNT];
    logic [CNT_W-1:0]   w_cntNext [NUM_CNT];
    logic [NUM_CNT-1:0] w_inc;
    logic [NUM_CNT-1:0] w_allOnes;
    logic [NUM_CNT-1:0] w_ovEvent;
    logic [NUM_CNT-1:0] r_overflow;
    logic [CNT_W-1:0]   w_rdSel;
    logic [CNT_W-1:0]   r_rdData;
    logic               w_running;

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state logic; clear overrides every transition. A halt wins over
    // run so the core stopping always freezes the statistics.
    always_comb begin
        w_stateNext = r_state;
        if (clear) begin
            w_stateNext = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (run) begin
                        w_stateNext = RUN;
                    end
                end
                RUN: begin
                    if (hlt) begin
                        w_stateNext = FROZEN;
                    end else if (!run) begin
                        w_stateNext = IDLE;
                    end
                end
                FROZEN: begin
                    w_stateNext = FROZEN;
                end
                default: begin
                    w_stateNext = IDLE;
                end
            endcase
        end
    end

    assign state = r_state;

    // ------------------------------------------------------------------------
    // Counter datapath
    // ------------------------------------------------------------------------

    // Counting is gated by the current (registered) state, so the cycle in
    // which hlt arrives is still counted while the run-rise cycle is not.
    assign w_running                = (r_state == RUN);
    assign w_inc[NUM_EVENTS-1:0]    = events & {NUM_EVENTS{w_running}};
    assign w_inc[NUM_EVENTS]        = w_running;

    // Per-counter increment, overflow detect and saturate/wrap selection.
    for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
        assign w_allOnes[i] = &r_liveCnt[i];
        assign w_ovEvent[i] = w_inc[i] & w_allOnes[i];
        // With SAT=0 the plain +1 wraps all-ones to zero on its own.
        assign w_cntNext[i] = (w_ovEvent[i] && (SAT != 0))
                            ? r_liveCnt[i]
                            : r_liveCnt[i] + CNT_W'(w_inc[i]);
    end

    // Live counters and sticky overflow flags; clear beats counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                r_liveCnt[i] <= '0;
            end
            r_overflow <= '0;
        end else if (clear) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                r_liveCnt[i] <= '0;
            end
            r_overflow <= '0;
        end else begin
            for (int i = 0; i < NUM_CNT; i++) begin
                r_liveCnt[i] <= w_cntNext[i];
            end
            r_overflow <= r_overflow | w_ovEvent;
        end
    end

    assign overflow = r_overflow;

    // Snapshot bank captures pre-update live values; untouched by clear so a
    // simultaneous snap+clear preserves the final statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                r_snapCnt[i] <= '0;
            end
        end else if (snap) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                r_snapCnt[i] <= r_liveCnt[i];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read port
    // ------------------------------------------------------------------------

    // Index decode; indices beyond the cycle counter match nothing and read 0.
    always_comb begin
        w_rdSel = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                w_rdSel = r_snapCnt[i];
            end
        end
    end

    // Registered read data, one cycle behind rd_idx.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdData <= '0;
        end else begin
            r_rdData <= w_rdSel;
        end
    end

    assign rd_data = r_rdData;

endmodule
`default_nettype wire
